// File: rtl/sgd_pkg.sv
// sgd_pkg: shared types and arithmetic helpers for the SGD trainer.
// Helpers work on 64-bit signed values; callers size-cast results to W.
package sgd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL,
    ERR,
    UPD,
    FIN
  } state_t;

  // Clamp a wide signed value into the range of a w-bit signed word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r  = v;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    return r;
  endfunction

  // Saturating add of two sign-extended w-bit words.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return sat_w(a + b, w);
  endfunction

  // Fixed-point multiply: full product, arithmetic shift by frac; caller truncates.
  function automatic logic signed [63:0] qmul(input logic signed [63:0] a,
                                              input logic signed [63:0] b,
                                              input int frac);
    return (a * b) >>> frac;
  endfunction

endpackage

// File: rtl/sgd_qmul_lane.sv
// sgd_qmul_lane: one signed W x W fixed-point multiplier lane (>>> FRAC, truncated to W).
module sgd_qmul_lane
  import sgd_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  // Product truncated back to the Q format word; wraps on overflow.
  always_comb begin
    p = W'(qmul(64'(a), 64'(b), FRAC));
  end

endmodule

// File: rtl/sgd_trainer_p.sv
// sgd_trainer_p: parametrised SGD linear-regression trainer.
// Per sample: FETCH (handshake) -> MUL -> ERR -> UPD, then next sample or FIN.
// Optional macro SGD_SAT_EN: weight updates saturate instead of wrapping.
module sgd_trainer_p
  import sgd_pkg::*;
#(
  parameter int NF   = 15,
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int AW   = 12,
  parameter int EW   = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [4:0]            num_feat,
  input  logic [AW-1:0]         num_samples,
  input  logic [EW-1:0]         epochs,
  input  logic [3:0]            lr_shift,
  input  logic [(NF+1)*W-1:0]   w_init,
  output logic [AW-1:0]         addr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NF*W-1:0]       s_x,
  input  logic [W-1:0]          s_y,
  output logic [(NF+1)*W-1:0]   w_out,
  output logic                  busy,
  output logic                  done,
  output logic [EW-1:0]         epoch_cnt
);

  localparam int ACC_W = W + $clog2(NF + 1);
  localparam int ERR_W = ACC_W + 1;

  state_t state, state_nxt;

  logic signed [W-1:0] w_reg  [0:NF];
  logic signed [W-1:0] w_upd  [0:NF];
  logic signed [W-1:0] x_in   [1:NF];
  logic signed [W-1:0] a_reg  [1:NF];
  logic signed [W-1:0] b_reg  [1:NF];
  logic signed [W-1:0] p_reg  [1:NF];
  logic signed [W-1:0] lane_p [1:NF];
  logic signed [W-1:0] y_reg;
  logic signed [W-1:0] delta;
  logic signed [W-1:0] delta_nxt;
  logic signed [W-1:0] err_sat;
  logic signed [ACC_W-1:0] yhat;
  logic signed [ERR_W-1:0] err_wide;

  logic [4:0]    nf_cfg;
  logic [4:0]    nf_clamped;
  logic [3:0]    lr_cfg;
  logic [AW-1:0] ns_cfg;
  logic [EW-1:0] ep_cfg;
  logic          handshake;
  logic          last_sample;
  logic          last_epoch;

  // Lane unpacking (x[1] in the MSB word) and the shared multiplier bank.
  for (genvar k = 1; k <= NF; k++) begin : g_lane
    assign x_in[k] = s_x[(NF-k)*W +: W];
    sgd_qmul_lane #(.W(W), .FRAC(FRAC)) u_lane (
      .a (a_reg[k]),
      .b (b_reg[k]),
      .p (lane_p[k])
    );
  end

  // Live weights packed with W[0] in the MSB word.
  for (genvar k = 0; k <= NF; k++) begin : g_pack
    assign w_out[(NF-k)*W +: W] = w_reg[k];
  end

  // Clamp the requested feature count into 1..NF.
  always_comb begin
    nf_clamped = num_feat;
    if (num_feat == 5'd0) nf_clamped = 5'd1;
    else if (32'(num_feat) > NF) nf_clamped = 5'(NF);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and stream handshake decode.
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    handshake   = 1'b0;
    last_sample = (addr == (ns_cfg - AW'(1)));
    last_epoch  = ((epoch_cnt + EW'(1)) == ep_cfg);
    case (state)
      IDLE: begin
        if (start) begin
          if ((num_samples == '0) || (epochs == '0)) state_nxt = FIN;
          else                                       state_nxt = FETCH;
        end
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) begin
          handshake = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL:     state_nxt = ERR;
      ERR:     state_nxt = UPD;
      UPD:     state_nxt = (last_sample && last_epoch) ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Prediction from registered products, saturated error and scaled step.
  always_comb begin
    yhat = ACC_W'(w_reg[0]);
    for (int k = 1; k <= NF; k++) yhat = yhat + ACC_W'(p_reg[k]);
    err_wide  = ERR_W'(y_reg) - ERR_W'(yhat);
    err_sat   = W'(sat_w(64'(err_wide), W));
    delta_nxt = err_sat >>> lr_cfg;
  end

  // Candidate weights: bias gets the step, lanes get x * step from the bank.
  always_comb begin
`ifdef SGD_SAT_EN
    w_upd[0] = W'(sat_add(64'(w_reg[0]), 64'(delta), W));
    for (int k = 1; k <= NF; k++) w_upd[k] = W'(sat_add(64'(w_reg[k]), 64'(lane_p[k]), W));
`else
    w_upd[0] = w_reg[0] + delta;
    for (int k = 1; k <= NF; k++) w_upd[k] = w_reg[k] + lane_p[k];
`endif
  end

  // Datapath and status registers, sequenced by the FSM state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k <= NF; k++) w_reg[k] <= '0;
      for (int k = 1; k <= NF; k++) begin
        a_reg[k] <= '0;
        b_reg[k] <= '0;
        p_reg[k] <= '0;
      end
      y_reg     <= '0;
      delta     <= '0;
      nf_cfg    <= 5'd1;
      lr_cfg    <= '0;
      ns_cfg    <= '0;
      ep_cfg    <= '0;
      addr      <= '0;
      epoch_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nf_cfg    <= nf_clamped;
            lr_cfg    <= lr_shift;
            ns_cfg    <= num_samples;
            ep_cfg    <= epochs;
            for (int k = 0; k <= NF; k++) w_reg[k] <= w_init[(NF-k)*W +: W];
            addr      <= '0;
            epoch_cnt <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (handshake) begin
            for (int k = 1; k <= NF; k++) begin
              a_reg[k] <= (k <= int'(nf_cfg)) ? x_in[k] : '0;
              b_reg[k] <= w_reg[k];
            end
            y_reg <= s_y;
          end
        end
        MUL: begin
          for (int k = 1; k <= NF; k++) p_reg[k] <= lane_p[k];
        end
        ERR: begin
          delta <= delta_nxt;
          for (int k = 1; k <= NF; k++) b_reg[k] <= delta_nxt;
        end
        UPD: begin
          for (int k = 0; k <= NF; k++) w_reg[k] <= w_upd[k];
          if (last_sample) begin
            addr      <= '0;
            epoch_cnt <= epoch_cnt + EW'(1);
          end else begin
            addr <= addr + AW'(1);
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sgd_trainer_p.sv
// tb_sgd_trainer_p: randomized bench for sgd_trainer_p against a dataset-level SGD model.
module tb_sgd_trainer_p;

  localparam int NF   = 4;
  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int AW   = 12;
  localparam int EW   = 8;
  localparam int RAM  = 16;

  logic                CLK;
  logic                RST_N;
  logic                start;
  logic [4:0]          num_feat;
  logic [AW-1:0]       num_samples;
  logic [EW-1:0]       epochs;
  logic [3:0]          lr_shift;
  logic [(NF+1)*W-1:0] w_init;
  logic [AW-1:0]       addr;
  logic                s_valid;
  logic                s_ready;
  logic [NF*W-1:0]     s_x;
  logic [W-1:0]        s_y;
  logic [(NF+1)*W-1:0] w_out;
  logic                busy;
  logic                done;
  logic [EW-1:0]       epoch_cnt;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] ram_x [0:RAM-1][1:NF];
  logic signed [W-1:0] ram_y [0:RAM-1];
  logic signed [W-1:0] winit_arr [0:NF];
  longint              exp_w [0:NF];

  int                  stall_mode = 0;
  int                  stall_cnt  = 0;
  logic [(NF+1)*W-1:0] w_snap;

  sgd_trainer_p #(.NF(NF), .W(W), .FRAC(FRAC), .AW(AW), .EW(EW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .num_feat    (num_feat),
    .num_samples (num_samples),
    .epochs      (epochs),
    .lr_shift    (lr_shift),
    .w_init      (w_init),
    .addr        (addr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_x         (s_x),
    .s_y         (s_y),
    .w_out       (w_out),
    .busy        (busy),
    .done        (done),
    .epoch_cnt   (epoch_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] getW(input int i);
    return w_out[(NF-i)*W +: W];
  endfunction

  function automatic longint wrapw(input longint v);
    longint m;
    m = v & 64'hFFFF;
    if (m >= 32768) m = m - 65536;
    return m;
  endfunction

  function automatic longint clampw(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint updw(input longint v);
`ifdef SGD_SAT_EN
    return clampw(v);
`else
    return wrapw(v);
`endif
  endfunction

  // Plain SGD over the sample table: bias input 1, features masked to the active count.
  task automatic modelRun(input int nf, input int ns, input int ep, input int lr);
    int     nfe;
    longint w [0:NF];
    longint x;
    longint yhat;
    longint err;
    longint d;
    nfe = (nf == 0) ? 1 : ((nf > NF) ? NF : nf);
    for (int i = 0; i <= NF; i++) w[i] = winit_arr[i];
    for (int e = 0; e < ep; e++) begin
      for (int s = 0; s < ns; s++) begin
        yhat = w[0];
        for (int k = 1; k <= NF; k++) begin
          x = 0;
          if (k <= nfe) x = ram_x[s][k];
          yhat += wrapw((x * w[k]) >>> FRAC);
        end
        err  = clampw(longint'(ram_y[s]) - yhat);
        d    = err >>> lr;
        w[0] = updw(w[0] + d);
        for (int k = 1; k <= NF; k++) begin
          x = 0;
          if (k <= nfe) x = ram_x[s][k];
          w[k] = updw(w[k] + wrapw((x * d) >>> FRAC));
        end
      end
    end
    for (int i = 0; i <= NF; i++) exp_w[i] = w[i];
  endtask

  task automatic fillRandom(input int ns, input bit full);
    for (int s = 0; s < ns; s++) begin
      for (int k = 1; k <= NF; k++)
        ram_x[s][k] = full ? W'($urandom) : W'($urandom_range(0, 1023) - 512);
      ram_y[s] = full ? W'($urandom) : W'($urandom_range(0, 2047) - 1024);
    end
    for (int i = 0; i <= NF; i++)
      winit_arr[i] = full ? W'($urandom) : W'($urandom_range(0, 1023) - 512);
  endtask

  // Sample source: serves the table at addr; optional random or one-shot stall at addr 2.
  always @(negedge CLK) begin
    s_valid = 1'b1;
    if (stall_mode == 1) s_valid = ($urandom_range(0, 3) != 0);
    if (stall_mode == 2 && stall_cnt > 0 && stall_cnt < 7) begin
      checkOutput("stall_addr", addr, 2);
      checkOutput("stall_w", w_out, w_snap);
      checkOutput("stall_ready", s_ready, 1);
      s_valid = 1'b0;
      stall_cnt++;
    end else if (stall_mode == 2 && stall_cnt == 0 && s_ready && addr == 2) begin
      w_snap    = w_out;
      s_valid   = 1'b0;
      stall_cnt = 1;
    end
    for (int k = 1; k <= NF; k++)
      s_x[(NF-k)*W +: W] = (addr < RAM) ? ram_x[addr][k] : '0;
    s_y = (addr < RAM) ? ram_y[addr] : '0;
  end

  // One full training run, checked against the model at completion.
  task automatic applyStimulus(input int nf, input int ns, input int ep, input int lr,
                               input int mode, input bit glitch);
    int          budget;
    int          cyc;
    bit          seen;
    logic [W-1:0] e16;
    stall_mode = mode;
    stall_cnt  = 0;
    @(negedge CLK);
    num_feat    = 5'(nf);
    num_samples = AW'(ns);
    epochs      = EW'(ep);
    lr_shift    = 4'(lr);
    for (int k = 0; k <= NF; k++) w_init[(NF-k)*W +: W] = winit_arr[k];
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    checkOutput("done_clr", done, 0);
    checkOutput("w_loaded", w_out, w_init);
    budget = ns * ep * 40 + 20;
    seen   = 1'b0;
    cyc    = 0;
    while (cyc < budget) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (glitch && cyc == 3) begin
        start    = 1'b1;
        num_feat = 5'd1;
        lr_shift = 4'd7;
        epochs   = EW'(1);
      end else if (glitch && cyc == 4) begin
        start = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    checkOutput("timeout", seen, 1);
    if (ns == 0 || ep == 0) checkOutput("done_lat", cyc, 1);
    modelRun(nf, ns, ep, lr);
    for (int i = 0; i <= NF; i++) begin
      e16 = exp_w[i][W-1:0];
      checkOutput($sformatf("w%0d", i), getW(i), e16);
    end
    checkOutput("epoch_cnt", epoch_cnt, (ns == 0 || ep == 0) ? 0 : ep);
    checkOutput("busy_end", busy, 0);
    checkOutput("addr_end", addr, 0);
    stall_mode = 0;
  endtask

  initial begin
    int                  v;
    logic signed [W-1:0] t;
    int                  cyc;
    RST_N       = 1'b0;
    start       = 1'b0;
    num_feat    = '0;
    num_samples = '0;
    epochs      = '0;
    lr_shift    = '0;
    w_init      = '0;
    for (int s = 0; s < RAM; s++) begin
      for (int k = 1; k <= NF; k++) ram_x[s][k] = '0;
      ram_y[s] = '0;
    end
    for (int i = 0; i <= NF; i++) winit_arr[i] = '0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_w", w_out, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_epoch", epoch_cnt, 0);
    checkOutput("rst_ready", s_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    RST_N = 1'b1;

    // Single update with two active lanes.
    ram_x[0][1] = 16'h0100;
    ram_y[0]    = 16'h0200;
    applyStimulus(2, 1, 1, 1, 0, 1'b0);
    checkOutput("single_w0", getW(0), 16'h0100);
    checkOutput("single_w1", getW(1), 16'h0100);
    checkOutput("single_w2", getW(2), 16'h0000);
    checkOutput("single_done", done, 1);

    // Zero configurations finish immediately with w_init untouched.
    fillRandom(4, 1'b0);
    applyStimulus(3, 4, 0, 2, 0, 1'b0);
    applyStimulus(3, 0, 5, 2, 0, 1'b0);

    // Bias overflow: large positive error on a near-full bias.
    for (int s = 0; s < RAM; s++) begin
      for (int k = 1; k <= NF; k++) ram_x[s][k] = '0;
      ram_y[s] = '0;
    end
    ram_x[0][1] = 16'h0100;
    ram_y[0]    = 16'h7FFF;
    for (int i = 0; i <= NF; i++) winit_arr[i] = '0;
    winit_arr[0] = 16'h7F00;
    winit_arr[1] = 16'h9000;
    applyStimulus(1, 1, 1, 0, 0, 1'b0);
`ifdef SGD_SAT_EN
    checkOutput("ovf_w0", getW(0), 16'h7FFF);
`else
    checkOutput("ovf_w0", getW(0), 16'hEFFF);
`endif

    // Convergence on y = 2*x1 + 1; the other lanes carry noise that must be masked.
    fillRandom(4, 1'b0);
    for (int s = 0; s < 4; s++) begin
      ram_x[s][1] = W'(s * 16'h0080);
      ram_y[s]    = W'(2 * s * 16'h0080 + 16'h0100);
    end
    for (int i = 0; i <= NF; i++) winit_arr[i] = '0;
    applyStimulus(1, 4, 50, 2, 0, 1'b0);
    t = getW(1);
    v = t;
    checkOutput("conv_w1", (v >= 16'h01F0 && v <= 16'h0210), 1);
    t = getW(0);
    v = t;
    checkOutput("conv_w0", (v >= 16'h00F0 && v <= 16'h0110), 1);

    // Seven-cycle backpressure at addr 2.
    fillRandom(5, 1'b0);
    applyStimulus(4, 5, 2, 3, 2, 1'b0);

    // Randomized runs, including clamped feature counts and a start while busy.
    for (int r = 0; r < 8; r++) begin
      int ns;
      ns = $urandom_range(3, 6);
      fillRandom(ns, (r == 5));
      applyStimulus($urandom_range(0, 6), ns, $urandom_range(1, 4), $urandom_range(0, 7),
                    1, (r == 2));
    end

    // Reset while the trainer sits in UPD, then a clean rerun.
    fillRandom(4, 1'b0);
    stall_mode = 0;
    @(negedge CLK);
    num_feat    = 5'd3;
    num_samples = AW'(4);
    epochs      = EW'(3);
    lr_shift    = 4'd2;
    for (int k = 0; k <= NF; k++) w_init[(NF-k)*W +: W] = winit_arr[k];
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 0;
    while (cyc < 100 && !(s_ready && addr == 1)) begin
      @(negedge CLK);
      cyc++;
    end
    checkOutput("rst_mid_reach", (cyc < 100), 1);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b0;
    @(negedge CLK);
    checkOutput("mid_w", w_out, 0);
    checkOutput("mid_addr", addr, 0);
    checkOutput("mid_epoch", epoch_cnt, 0);
    checkOutput("mid_ready", s_ready, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_done", done, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus(3, 4, 3, 2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
